// File: rtl/proc_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | proc_pkg : opcodes, FSM states and instruction field positions          |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package proc_pkg;

  localparam int INSTR_W  = 32;
  localparam int OP_LSB   = 0;
  localparam int OP_W     = 4;
  localparam int X_LSB    = 4;
  localparam int Y_LSB    = 8;
  localparam int IDX_W    = 4;
  localparam int SEL_BIT  = 12;
  localparam int IMM_LSB  = 13;
  localparam int IMM_W    = INSTR_W - IMM_LSB;
  // Register file is addressed by a 4-bit field, so it always has 16 slots.
  localparam int RF_SLOTS = 1 << IDX_W;

  typedef enum logic [3:0] {
    OP_MV   = 4'd0,
    OP_MVI  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_LD   = 4'd4,
    OP_ST   = 4'd5,
    OP_BNZ  = 4'd6,
    OP_HALT = 4'd7,
    OP_MUL  = 4'd8
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/proc_mc_param_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | proc_mc_param_if : instruction fetch port and data memory/bus port      |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface proc_mc_param_if import proc_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8
);

  logic [IMEM_AW-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               mem_en;
  logic               mem_we;
  logic               mem_sel;
  logic [DMEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_rdata;
  logic               mem_ready;

  modport master (
    output imem_addr, mem_en, mem_we, mem_sel, mem_addr, mem_wdata,
    input  imem_rdata, mem_rdata, mem_ready
  );

  modport slave (
    input  imem_addr, mem_en, mem_we, mem_sel, mem_addr, mem_wdata,
    output imem_rdata, mem_rdata, mem_ready
  );

endinterface
`default_nettype wire

// File: rtl/proc_alu.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | proc_alu : combinational add/sub; multiply only when PROC_MUL_EN is set |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module proc_alu import proc_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] res_o
);

  always_comb begin
    res_o = a_i + b_i;
    case (op_i)
      OP_SUB:  res_o = a_i - b_i;
`ifdef PROC_MUL_EN
      OP_MUL:  res_o = a_i * b_i;
`endif
      default: res_o = a_i + b_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/proc_mc_param.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | proc_mc_param : multicycle accumulator-bus processor (opt. PROC_MUL_EN) |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module proc_mc_param import proc_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 8,
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8
) (
  input  logic            Clock,
  input  logic            Resetn,
  proc_mc_param_if.master bus,
  output logic            Done,
  output logic            halted
);

  state_t             state_q, state_d;
  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, wdata_q, wdata_d;
  logic [DMEM_AW-1:0] addr_q, addr_d;

  logic [DATA_W-1:0]  rf [RF_SLOTS];
  logic               rf_we;
  logic [IDX_W-1:0]   rf_widx;
  logic [DATA_W-1:0]  rf_wdata;

  logic [OP_W-1:0]    op;
  logic [IDX_W-1:0]   x_idx, y_idx;
  logic [INSTR_W-1:0] imm_ext;
  logic [DATA_W-1:0]  rx, ry, alu_res;

  assign op      = ir_q[OP_LSB +: OP_W];
  assign x_idx   = ir_q[X_LSB +: IDX_W];
  assign y_idx   = ir_q[Y_LSB +: IDX_W];
  assign imm_ext = {{IMM_LSB{1'b0}}, ir_q[INSTR_W-1:IMM_LSB]};
  assign rx      = rf[x_idx];
  assign ry      = rf[y_idx];

  // Slots at or above NREGS are constant zero, so reads of them give 0 and writes vanish.
  for (genvar i = 0; i < RF_SLOTS; i++) begin : g_rf
    if (i < NREGS) begin : g_live
      logic [DATA_W-1:0] reg_q;
      always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)                               reg_q <= '0;
        else if (rf_we && rf_widx == IDX_W'(i))    reg_q <= rf_wdata;
      end
      assign rf[i] = reg_q;
    end else begin : g_absent
      assign rf[i] = '0;
    end
  end

  proc_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i  (op),
    .a_i   (a_q),
    .b_i   (b_q),
    .res_o (alu_res)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rf_we    = 1'b0;
    rf_widx  = x_idx;
    rf_wdata = alu_res;
    Done     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_d    = bus.imem_rdata;
        pc_d    = pc_q + 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        Done    = 1'b1;
        state_d = S_FETCH;
        case (op)
          OP_MV:   begin rf_we = 1'b1; rf_wdata = ry; end
          OP_MVI:  begin rf_we = 1'b1; rf_wdata = imm_ext[DATA_W-1:0]; end
          OP_ADD, OP_SUB: begin
            a_d = rx; b_d = ry; Done = 1'b0; state_d = S_EXEC;
          end
`ifdef PROC_MUL_EN
          OP_MUL: begin
            a_d = rx; b_d = ry; Done = 1'b0; state_d = S_EXEC;
          end
`endif
          OP_LD: begin
            addr_d = rx[DMEM_AW-1:0]; Done = 1'b0; state_d = S_MEM;
          end
          OP_ST: begin
            addr_d = rx[DMEM_AW-1:0]; wdata_d = ry; Done = 1'b0; state_d = S_MEM;
          end
          // Taken branch replaces the increment already applied during FETCH.
          OP_BNZ:  if (ry != '0) pc_d = imm_ext[IMEM_AW-1:0];
          OP_HALT: state_d = S_HALT;
          default: ;
        endcase
      end
      S_EXEC: begin
        rf_we   = 1'b1;
        Done    = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          Done    = 1'b1;
          state_d = S_FETCH;
          if (op == OP_LD) begin
            rf_we    = 1'b1;
            rf_widx  = y_idx;
            rf_wdata = bus.mem_rdata;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Decoded from state so an asynchronous reset drops the request at once.
  assign bus.imem_addr = pc_q;
  assign bus.mem_en    = (state_q == S_MEM);
  assign bus.mem_we    = bus.mem_en && (op == OP_ST);
  assign bus.mem_sel   = bus.mem_en && ir_q[SEL_BIT];
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign halted        = (state_q == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_proc_mc_param.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_proc_mc_param : directed program table plus reset/halt/wrap cases    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_proc_mc_param;
  import proc_pkg::*;

  localparam int NV = 9;
  localparam logic [31:0] HALT_W = 32'h0000_0007;

  typedef struct {
    logic [7:0][31:0] prog;
    int               wait_n;
    logic [31:0]      ld_data;
    int               exp_st;
    int               exp_ld;
    logic [7:0]       exp_addr;
    logic [31:0]      exp_data;
    logic             exp_sel;
    int               exp_halt;
    logic [63:0]      exp_done;
    int               exp_en;
  } vec_t;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Done, halted;
  logic [31:0] imem [256];
  vec_t        vt [NV];

  int          checks = 0;
  int          errors = 0;
  int          n_store, n_load, en_cyc, viol, halt_cyc;
  logic [63:0] done_mask;
  logic [7:0]  st_addr;
  logic [31:0] st_data;
  logic        st_sel;

  always #5 Clock = ~Clock;

  proc_mc_param_if #(.DATA_W(32), .IMEM_AW(8), .DMEM_AW(8)) bus ();
  assign bus.imem_rdata = imem[bus.imem_addr];

  proc_mc_param #(.DATA_W(32), .NREGS(8), .IMEM_AW(8), .DMEM_AW(8)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus),
    .Done   (Done),
    .halted (halted)
  );

  function automatic logic [31:0] enc(input logic [3:0] o, input logic [3:0] x,
                                      input logic [3:0] y, input logic s, input logic [18:0] imm);
    return {imm, s, y, x, o};
  endfunction
  function automatic logic [31:0] mvi(input logic [3:0] x, input logic [18:0] imm);
    return enc(OP_MVI, x, 4'd0, 1'b0, imm);
  endfunction
  function automatic logic [31:0] rr(input logic [3:0] o, input logic [3:0] x, input logic [3:0] y);
    return enc(o, x, y, 1'b0, 19'd0);
  endfunction
  function automatic logic [63:0] B(input int k);
    return 64'd1 << k;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic load_prog(input logic [7:0][31:0] p);
    for (int j = 0; j < 256; j++) imem[j] = HALT_W;
    for (int j = 0; j < 8; j++)   imem[j] = p[j];
  endtask

  task automatic apply_reset();
    Resetn = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = '0;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
  endtask

  // Sample k is cycle k after reset release; ready is held high whenever mem_en is low.
  task automatic run_prog(input int wait_n, input logic [31:0] ld, input int max_cyc);
    int wcnt; logic prev_en, pwe, psel; logic [7:0] pa; logic [31:0] pw;
    n_store = 0; n_load = 0; en_cyc = 0; viol = 0; halt_cyc = -1; done_mask = '0;
    st_addr = '0; st_data = '0; st_sel = 1'b0;
    wcnt = 0; prev_en = 1'b0; pwe = 1'b0; psel = 1'b0; pa = '0; pw = '0;
    for (int k = 1; k <= max_cyc && halt_cyc < 0; k++) begin
      #1;
      if (bus.mem_en) begin
        bus.mem_ready = (wcnt >= wait_n);
        bus.mem_rdata = bus.mem_ready ? ld : ~ld;
      end else begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = ~ld;
        wcnt = 0;
      end
      #1;
      if (halted) halt_cyc = k;
      if (Done && k < 64) done_mask[k] = 1'b1;
      if (bus.mem_en) begin
        en_cyc++;
        if (prev_en && (bus.mem_addr !== pa || bus.mem_wdata !== pw ||
                        bus.mem_we !== pwe || bus.mem_sel !== psel)) viol++;
        pa = bus.mem_addr; pw = bus.mem_wdata; pwe = bus.mem_we; psel = bus.mem_sel;
        if (bus.mem_ready) begin
          if (bus.mem_we) begin
            n_store++; st_addr = bus.mem_addr; st_data = bus.mem_wdata; st_sel = bus.mem_sel;
          end else n_load++;
        end else wcnt++;
      end
      prev_en = bus.mem_en;
      if (halt_cyc < 0) @(negedge Clock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic got;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = '0;
    for (int j = 0; j < 256; j++) imem[j] = HALT_W;

    for (int i = 0; i < NV; i++) begin
      for (int j = 0; j < 8; j++) vt[i].prog[j] = HALT_W;
      vt[i].wait_n = 0; vt[i].ld_data = '0; vt[i].exp_st = 1; vt[i].exp_ld = 0;
      vt[i].exp_addr = 8'h00; vt[i].exp_sel = 1'b0; vt[i].exp_en = 1;
    end
    // arithmetic: 5+3 stored at address 0
    vt[0].prog[0] = mvi(4'd1, 19'd5); vt[0].prog[1] = mvi(4'd2, 19'd3);
    vt[0].prog[2] = rr(OP_ADD, 4'd1, 4'd2); vt[0].prog[3] = rr(OP_ST, 4'd0, 4'd1);
    vt[0].exp_data = 32'd8; vt[0].exp_halt = 13; vt[0].exp_done = B(2)|B(4)|B(7)|B(10)|B(12);
    // subtract wrap: 3-5
    vt[1].prog[0] = mvi(4'd1, 19'd3); vt[1].prog[1] = mvi(4'd2, 19'd5);
    vt[1].prog[2] = rr(OP_SUB, 4'd1, 4'd2); vt[1].prog[3] = rr(OP_ST, 4'd0, 4'd1);
    vt[1].exp_data = 32'hFFFF_FFFE; vt[1].exp_halt = 13; vt[1].exp_done = B(2)|B(4)|B(7)|B(10)|B(12);
    // two wait states on the store
    vt[2].prog = vt[0].prog; vt[2].wait_n = 2; vt[2].exp_data = 32'd8; vt[2].exp_en = 3;
    vt[2].exp_halt = 15; vt[2].exp_done = B(2)|B(4)|B(7)|B(12)|B(14);
    // load then store of the loaded value, one wait state each, sel=1 on the store
    vt[3].prog[0] = mvi(4'd1, 19'h20); vt[3].prog[1] = rr(OP_LD, 4'd1, 4'd3);
    vt[3].prog[2] = enc(OP_ST, 4'd1, 4'd3, 1'b1, 19'd0);
    vt[3].wait_n = 1; vt[3].ld_data = 32'hDEAD_BEEF; vt[3].exp_ld = 1; vt[3].exp_addr = 8'h20;
    vt[3].exp_data = 32'hDEAD_BEEF; vt[3].exp_sel = 1'b1; vt[3].exp_en = 4;
    vt[3].exp_halt = 13; vt[3].exp_done = B(2)|B(6)|B(10)|B(12);
    // countdown loop: body runs 3 times
    vt[4].prog[0] = mvi(4'd1, 19'd1); vt[4].prog[1] = mvi(4'd2, 19'd3);
    vt[4].prog[2] = rr(OP_SUB, 4'd2, 4'd1); vt[4].prog[3] = enc(OP_BNZ, 4'd0, 4'd2, 1'b0, 19'd2);
    vt[4].prog[4] = rr(OP_ST, 4'd0, 4'd2);
    vt[4].exp_data = 32'd0; vt[4].exp_halt = 25;
    vt[4].exp_done = B(2)|B(4)|B(7)|B(9)|B(12)|B(14)|B(17)|B(19)|B(22)|B(24);
    // register 9 is out of range: write ignored, read is 0
    vt[5].prog[0] = mvi(4'd1, 19'd5); vt[5].prog[1] = mvi(4'd9, 19'd7);
    vt[5].prog[2] = rr(OP_MV, 4'd1, 4'd9); vt[5].prog[3] = rr(OP_ST, 4'd0, 4'd1);
    vt[5].exp_data = 32'd0; vt[5].exp_halt = 12; vt[5].exp_done = B(2)|B(4)|B(6)|B(9)|B(11);
    // ADD R1,R1 reads the pre-write value
    vt[6].prog[0] = mvi(4'd1, 19'd5); vt[6].prog[1] = rr(OP_ADD, 4'd1, 4'd1);
    vt[6].prog[2] = rr(OP_ST, 4'd0, 4'd1);
    vt[6].exp_data = 32'd10; vt[6].exp_halt = 11; vt[6].exp_done = B(2)|B(5)|B(8)|B(10);
    // opcode 8: MUL when enabled, otherwise NOP
    vt[7].prog[0] = mvi(4'd1, 19'd4); vt[7].prog[1] = rr(OP_MUL, 4'd1, 4'd1);
    vt[7].prog[2] = rr(OP_ST, 4'd0, 4'd1);
`ifdef PROC_MUL_EN
    vt[7].exp_data = 32'd16; vt[7].exp_halt = 11; vt[7].exp_done = B(2)|B(5)|B(8)|B(10);
`else
    vt[7].exp_data = 32'd4;  vt[7].exp_halt = 10; vt[7].exp_done = B(2)|B(4)|B(7)|B(9);
`endif
    // full 19-bit immediate zero-extends; top register R7 usable
    vt[8].prog[0] = mvi(4'd7, 19'h7FFFF); vt[8].prog[1] = rr(OP_ST, 4'd0, 4'd7);
    vt[8].exp_data = 32'h0007_FFFF; vt[8].exp_halt = 8; vt[8].exp_done = B(2)|B(5)|B(7);

    // reset state while held in reset
    repeat (2) @(negedge Clock);
    #2;
    chk("rst_pc", 0, bus.imem_addr, 8'd0);
    chk("rst_mem_en", 0, bus.mem_en, 1'b0);
    chk("rst_mem_we", 0, bus.mem_we, 1'b0);
    chk("rst_done", 0, Done, 1'b0);
    chk("rst_halted", 0, halted, 1'b0);

    for (int i = 0; i < NV; i++) begin
      load_prog(vt[i].prog);
      apply_reset();
      run_prog(vt[i].wait_n, vt[i].ld_data, 60);
      chk("halt_cycle", i, halt_cyc, vt[i].exp_halt);
      chk("done_cycles", i, done_mask, vt[i].exp_done);
      chk("store_count", i, n_store, vt[i].exp_st);
      chk("load_count", i, n_load, vt[i].exp_ld);
      chk("store_addr", i, st_addr, vt[i].exp_addr);
      chk("store_data", i, st_data, vt[i].exp_data);
      chk("store_sel", i, st_sel, vt[i].exp_sel);
      chk("mem_en_cycles", i, en_cyc, vt[i].exp_en);
      chk("mem_stable", i, viol, 0);
    end

    // halt freezes the PC (HALT at address 4, so PC=5) and stays halted
    load_prog(vt[0].prog);
    apply_reset();
    run_prog(0, 32'h0, 60);
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock); #2;
      chk("halt_freeze", c, {Done, halted, bus.imem_addr}, {1'b0, 1'b1, 8'd5});
    end

    // branch to 255 where HALT sits; fetch increment wraps PC to 0
    load_prog(vt[8].prog);
    imem[0] = mvi(4'd1, 19'd1);
    imem[1] = enc(OP_BNZ, 4'd0, 4'd1, 1'b0, 19'd255);
    imem[2] = rr(OP_MV, 4'd0, 4'd0);
    apply_reset();
    run_prog(0, 32'h0, 40);
    chk("wrap_halt_cycle", 0, halt_cyc, 7);
    chk("wrap_pc", 0, bus.imem_addr, 8'd0);

    // asynchronous reset in the middle of a waiting store
    load_prog(vt[8].prog);
    imem[0] = rr(OP_ST, 4'd0, 4'd0);
    apply_reset();
    bus.mem_ready = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge Clock); #2;
      if (bus.mem_en) got = 1'b1;
    end
    chk("wait_entered", 0, got, 1'b1);
    @(negedge Clock); #2;
    chk("wait_holds_en", 0, {bus.mem_en, bus.mem_we, Done}, {1'b1, 1'b1, 1'b0});
    Resetn = 1'b0;
    #1;
    chk("async_rst_en", 0, bus.mem_en, 1'b0);
    chk("async_rst_pc", 0, bus.imem_addr, 8'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    #2;
    chk("post_rst_state", 0, {halted, bus.mem_en, bus.imem_addr}, {1'b0, 1'b0, 8'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
